// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : wb_scoreboard
// Description : Writeback scoreboard for the integer register file. Counts
//               outstanding writes per register, arbitrates EXU/LSU results
//               onto a registered write port and raises decode RAW stalls.
//               Optional bypass outputs: define WB_SCOREBOARD_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_issue_valid,
    input  logic [ADDR_W-1:0] i_issue_rd,
    output logic              o_issue_ready,
    input  logic [ADDR_W-1:0] i_raddr1,
    input  logic [ADDR_W-1:0] i_raddr2,
    output logic              o_raw_stall,
    input  logic              i_exu_valid,
    input  logic [ADDR_W-1:0] i_exu_rd,
    input  logic [DATA_W-1:0] i_exu_data,
    output logic              o_exu_ready,
    input  logic              i_lsu_valid,
    input  logic [ADDR_W-1:0] i_lsu_rd,
    input  logic [DATA_W-1:0] i_lsu_data,
    output logic              o_lsu_ready,
    output logic              o_wen,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [DATA_W-1:0] o_wdata,
`ifdef WB_SCOREBOARD_BYPASS_EN
    output logic              o_fwd1_sel,
    output logic              o_fwd2_sel,
    output logic [DATA_W-1:0] o_fwd1_data,
    output logic [DATA_W-1:0] o_fwd2_data,
`endif
    output logic              o_busy
);

    localparam int               c_NREG    = 2**ADDR_W;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [CNT_W-1:0]  w_cnt [c_NREG];
    logic [c_NREG-1:0] w_nxt_nz;
    logic              w_issue_fire;
    logic              w_lsu_fire;
    logic              w_exu_fire;
    logic              w_ret_fire;
    logic [ADDR_W-1:0] w_ret_rd;
    logic [DATA_W-1:0] w_ret_data;
    logic              r_wen;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_busy;
    logic              w_pend1, w_pend2;
    logic              w_hit1, w_hit2;
    logic              w_fwd1, w_fwd2;

    // x0 is never tracked
    assign w_cnt[0]    = '0;
    assign w_nxt_nz[0] = 1'b0;

    assign o_issue_ready = ~i_flush & ((i_issue_rd == '0) | (w_cnt[i_issue_rd] != c_CNT_MAX));
    assign o_lsu_ready   = ~i_flush;
    assign o_exu_ready   = ~i_flush & ~i_lsu_valid;

    assign w_issue_fire = i_issue_valid & o_issue_ready;
    assign w_lsu_fire   = i_lsu_valid & o_lsu_ready;
    assign w_exu_fire   = i_exu_valid & o_exu_ready;
    assign w_ret_fire   = w_lsu_fire | w_exu_fire;
    assign w_ret_rd     = w_lsu_fire ? i_lsu_rd   : i_exu_rd;
    assign w_ret_data   = w_lsu_fire ? i_lsu_data : i_exu_data;

    generate
        for (genvar i = 1; i < c_NREG; i++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_nxt;
            logic             w_inc;
            logic             w_dec;

            assign w_inc = w_issue_fire & (i_issue_rd == ADDR_W'(i));
            assign w_dec = w_ret_fire & (w_ret_rd == ADDR_W'(i));

            // Issue and retire to the same register cancel; retire at zero saturates
            always_comb begin
                w_cnt_nxt = r_cnt;
                if (i_flush)
                    w_cnt_nxt = '0;
                else if (w_inc & ~w_dec)
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                else if (w_dec & ~w_inc & (r_cnt != '0))
                    w_cnt_nxt = r_cnt - CNT_W'(1);
            end

            always_ff @(posedge clk) begin
                if (i_rst)
                    r_cnt <= '0;
                else
                    r_cnt <= w_cnt_nxt;
            end

            assign w_cnt[i]    = r_cnt;
            assign w_nxt_nz[i] = |w_cnt_nxt;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_wen  <= w_ret_fire & (w_ret_rd != '0);
            r_busy <= (|w_nxt_nz) | (w_ret_fire & (w_ret_rd != '0));
            if (w_ret_fire) begin
                r_waddr <= w_ret_rd;
                r_wdata <= w_ret_data;
            end
        end
    end

    assign o_wen   = r_wen;
    assign o_waddr = r_waddr;
    assign o_wdata = r_wdata;
    assign o_busy  = r_busy;

    // A source whose write is on the port this cycle is not yet in the register file
    assign w_pend1 = w_cnt[i_raddr1] != '0;
    assign w_pend2 = w_cnt[i_raddr2] != '0;
    assign w_hit1  = r_wen & (r_waddr == i_raddr1) & (i_raddr1 != '0);
    assign w_hit2  = r_wen & (r_waddr == i_raddr2) & (i_raddr2 != '0);

`ifdef WB_SCOREBOARD_BYPASS_EN
    assign w_fwd1      = w_hit1 & ~w_pend1;
    assign w_fwd2      = w_hit2 & ~w_pend2;
    assign o_fwd1_sel  = w_fwd1;
    assign o_fwd2_sel  = w_fwd2;
    assign o_fwd1_data = w_fwd1 ? r_wdata : '0;
    assign o_fwd2_data = w_fwd2 ? r_wdata : '0;
`else
    assign w_fwd1 = 1'b0;
    assign w_fwd2 = 1'b0;
`endif

    assign o_raw_stall = w_pend1 | (w_hit1 & ~w_fwd1) | w_pend2 | (w_hit2 & ~w_fwd2);

endmodule
`default_nettype wire

// File: tb/tb_wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_scoreboard
// Description : Directed plus randomized bench for wb_scoreboard against a
//               per-register pending-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_scoreboard;

    logic        clk;
    logic        i_rst, i_flush;
    logic        i_issue_valid;
    logic [4:0]  i_issue_rd;
    logic        o_issue_ready;
    logic [4:0]  i_raddr1, i_raddr2;
    logic        o_raw_stall;
    logic        i_exu_valid;
    logic [4:0]  i_exu_rd;
    logic [31:0] i_exu_data;
    logic        o_exu_ready;
    logic        i_lsu_valid;
    logic [4:0]  i_lsu_rd;
    logic [31:0] i_lsu_data;
    logic        o_lsu_ready;
    logic        o_wen;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata;
    logic        o_busy;
`ifdef WB_SCOREBOARD_BYPASS_EN
    logic        o_fwd1_sel, o_fwd2_sel;
    logic [31:0] o_fwd1_data, o_fwd2_data;
`endif

    wb_scoreboard #(.ADDR_W(5), .DATA_W(32), .CNT_W(2)) u_dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_flush       (i_flush),
        .i_issue_valid (i_issue_valid),
        .i_issue_rd    (i_issue_rd),
        .o_issue_ready (o_issue_ready),
        .i_raddr1      (i_raddr1),
        .i_raddr2      (i_raddr2),
        .o_raw_stall   (o_raw_stall),
        .i_exu_valid   (i_exu_valid),
        .i_exu_rd      (i_exu_rd),
        .i_exu_data    (i_exu_data),
        .o_exu_ready   (o_exu_ready),
        .i_lsu_valid   (i_lsu_valid),
        .i_lsu_rd      (i_lsu_rd),
        .i_lsu_data    (i_lsu_data),
        .o_lsu_ready   (o_lsu_ready),
        .o_wen         (o_wen),
        .o_waddr       (o_waddr),
        .o_wdata       (o_wdata),
`ifdef WB_SCOREBOARD_BYPASS_EN
        .o_fwd1_sel    (o_fwd1_sel),
        .o_fwd2_sel    (o_fwd2_sel),
        .o_fwd1_data   (o_fwd1_data),
        .o_fwd2_data   (o_fwd2_data),
`endif
        .o_busy        (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          pend [32];
    bit          m_wen;
    int          m_waddr;
    logic [31:0] m_wdata;
    bit          m_info;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit src_fwd(input int a);
`ifdef WB_SCOREBOARD_BYPASS_EN
        return (a != 0) && (pend[a] == 0) && m_wen && (m_waddr == a);
`else
        return (a < 0);
`endif
    endfunction

    function automatic bit src_stall(input int a);
        if (a == 0) return 1'b0;
        return ((pend[a] != 0) || (m_wen && m_waddr == a)) && !src_fwd(a);
    endfunction

    function automatic bit any_pend();
        for (int r = 1; r < 32; r++)
            if (pend[r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: check combinational outputs, advance model at the edge, check registered outputs
    task automatic step();
        bit          iss_rdy, iss, ret, hit;
        int          ird, rrd;
        logic [31:0] rdata;
        #1;
        ird     = int'(i_issue_rd);
        iss_rdy = !i_flush && (ird == 0 || pend[ird] != 3);
        chk("issue_ready", {31'd0, o_issue_ready}, {31'd0, iss_rdy});
        chk("lsu_ready", {31'd0, o_lsu_ready}, {31'd0, !i_flush});
        chk("exu_ready", {31'd0, o_exu_ready}, {31'd0, !i_flush && !i_lsu_valid});
        chk("raw_stall", {31'd0, o_raw_stall},
            {31'd0, src_stall(int'(i_raddr1)) || src_stall(int'(i_raddr2))});
`ifdef WB_SCOREBOARD_BYPASS_EN
        chk("fwd1_sel", {31'd0, o_fwd1_sel}, {31'd0, src_fwd(int'(i_raddr1))});
        chk("fwd2_sel", {31'd0, o_fwd2_sel}, {31'd0, src_fwd(int'(i_raddr2))});
        chk("fwd1_data", o_fwd1_data, src_fwd(int'(i_raddr1)) ? m_wdata : 32'd0);
        chk("fwd2_data", o_fwd2_data, src_fwd(int'(i_raddr2)) ? m_wdata : 32'd0);
`endif
        @(posedge clk);
        if (i_rst) begin
            for (int r = 0; r < 32; r++) pend[r] = 0;
            m_wen = 0; m_waddr = 0; m_wdata = 32'd0; m_info = 1;
        end else if (i_flush) begin
            for (int r = 0; r < 32; r++) pend[r] = 0;
            m_wen = 0; m_info = 0;
        end else begin
            iss   = i_issue_valid && iss_rdy;
            ret   = i_lsu_valid || i_exu_valid;
            rrd   = i_lsu_valid ? int'(i_lsu_rd) : int'(i_exu_rd);
            rdata = i_lsu_valid ? i_lsu_data : i_exu_data;
            hit   = iss && ret && (ird == rrd);
            if (!hit) begin
                if (iss && ird != 0) pend[ird]++;
                if (ret && rrd != 0 && pend[rrd] > 0) pend[rrd]--;
            end
            m_wen  = ret && (rrd != 0);
            m_info = ret;
            if (ret) begin
                m_waddr = rrd;
                m_wdata = rdata;
            end
        end
        #1;
        chk("wen", {31'd0, o_wen}, {31'd0, m_wen});
        chk("busy", {31'd0, o_busy}, {31'd0, any_pend() || m_wen});
        if (m_info) begin
            chk("waddr", {27'd0, o_waddr}, m_waddr[31:0]);
            chk("wdata", o_wdata, m_wdata);
        end
    endtask

    task automatic idle();
        i_rst = 0; i_flush = 0;
        i_issue_valid = 0; i_issue_rd = '0;
        i_raddr1 = '0; i_raddr2 = '0;
        i_exu_valid = 0; i_exu_rd = '0; i_exu_data = '0;
        i_lsu_valid = 0; i_lsu_rd = '0; i_lsu_data = '0;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) pend[r] = 0;
        m_wen = 0; m_waddr = 0; m_wdata = 32'd0; m_info = 0;
        idle();
        @(posedge clk);
        #1;

        // Reset state
        i_rst = 1; step();
        chk("rst_wen", {31'd0, o_wen}, 32'd0);
        chk("rst_waddr", {27'd0, o_waddr}, 32'd0);
        chk("rst_wdata", o_wdata, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);

        // Reset mid-operation
        idle(); i_issue_valid = 1; i_issue_rd = 5'd5; step(); step();
        chk("cnt5_busy", {31'd0, o_busy}, 32'd1);
        idle(); i_rst = 1; step();
        chk("midrst_busy", {31'd0, o_busy}, 32'd0);
        idle(); i_raddr1 = 5'd5; step();

        // RAW stall until writeback lands
        idle(); i_issue_valid = 1; i_issue_rd = 5'd7; i_raddr1 = 5'd7; step();
        idle(); i_raddr1 = 5'd7; step();
        idle(); i_raddr1 = 5'd7; i_exu_valid = 1; i_exu_rd = 5'd7; i_exu_data = 32'hDEADBEEF; step();
        chk("raw_wen", {31'd0, o_wen}, 32'd1);
        chk("raw_waddr", {27'd0, o_waddr}, 32'd7);
        chk("raw_wdata", o_wdata, 32'hDEADBEEF);
        idle(); i_raddr1 = 5'd7; step();
        idle(); i_raddr1 = 5'd7; step();

        // LSU wins arbitration, EXU follows next cycle
        idle(); i_exu_valid = 1; i_exu_rd = 5'd3; i_exu_data = 32'h11;
        i_lsu_valid = 1; i_lsu_rd = 5'd4; i_lsu_data = 32'h22; step();
        chk("arb_first", {27'd0, o_waddr}, 32'd4);
        i_lsu_valid = 0; step();
        chk("arb_second", {27'd0, o_waddr}, 32'd3);
        chk("arb_second_data", o_wdata, 32'h11);

        // Saturation and same-cycle collision
        idle(); i_issue_valid = 1; i_issue_rd = 5'd9; step(); step(); step();
        i_exu_valid = 1; i_exu_rd = 5'd9; i_exu_data = 32'h99; step();
        i_exu_valid = 0; step();
        step();

        // x0 and flush
        idle(); i_issue_valid = 1; i_issue_rd = 5'd0; i_exu_valid = 1; i_exu_rd = 5'd0;
        i_raddr1 = 5'd0; step();
        chk("x0_wen", {31'd0, o_wen}, 32'd0);
        idle(); i_rst = 1; step();
        idle(); i_issue_valid = 1; i_issue_rd = 5'd2; step();
        idle(); i_flush = 1; i_issue_valid = 1; i_issue_rd = 5'd2;
        i_exu_valid = 1; i_exu_rd = 5'd2; i_lsu_valid = 1; i_lsu_rd = 5'd2; step();
        chk("flush_busy", {31'd0, o_busy}, 32'd0);
        idle(); i_raddr1 = 5'd2; step();

        // In-flight write seen by source 2
        idle(); i_lsu_valid = 1; i_lsu_rd = 5'd6; i_lsu_data = 32'h55; i_raddr2 = 5'd6; step();
        idle(); i_raddr2 = 5'd6; step();

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            i_rst         = ($urandom_range(0, 99) < 2);
            i_flush       = ($urandom_range(0, 99) < 3);
            i_issue_valid = ($urandom_range(0, 99) < 60);
            i_issue_rd    = 5'($urandom_range(0, 9));
            i_raddr1      = 5'($urandom_range(0, 9));
            i_raddr2      = 5'($urandom_range(0, 9));
            i_exu_valid   = ($urandom_range(0, 99) < 40);
            i_exu_rd      = 5'($urandom_range(0, 9));
            i_exu_data    = $urandom;
            i_lsu_valid   = ($urandom_range(0, 99) < 25);
            i_lsu_rd      = 5'($urandom_range(0, 9));
            i_lsu_data    = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
